// File: rtl/instruction_loader.sv
// instruction_loader: assembles a UART byte stream (16-bit word count, then MSB-first words)
// into instruction-memory writes. Define INSTRUCTION_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
`ifndef CELL_NUMBERS
`define CELL_NUMBERS 1024
`endif

module instruction_loader #(
    parameter int unsigned instr_size   = 32,
    parameter int unsigned cell_numbers = `CELL_NUMBERS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [instr_size-1:0] load_address,
    output logic [instr_size-1:0] load_instruction,
    output logic                  we,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);
    localparam int unsigned BPW = instr_size / 8;
    localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERROR
    } state_t;

    // State entered once the payload is complete (or immediately when N=0).
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    localparam state_t TAIL = CHECK;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           word_q, word_d;
    logic [BCW-1:0]        byte_q, byte_d;
    logic [instr_size-9:0] shift_q, shift_d;
    logic [instr_size-1:0] addr_q, addr_d;
    logic [instr_size-1:0] instr_q, instr_d;
    logic                  we_q, we_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic [instr_size-1:0] word_in;
    logic [31:0]           len_bytes;

    assign word_in   = {shift_q, rx_data};
    assign len_bytes = 32'({len_hi_q, rx_data}) * BPW;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LEN_HI;
            len_hi_q <= '0;
            count_q  <= '0;
            word_q   <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
            addr_q   <= '0;
            instr_q  <= '0;
            we_q     <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            count_q  <= count_d;
            word_q   <= word_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            we_q     <= we_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        count_d  = count_q;
        word_d   = word_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        we_d     = 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            LEN_HI: begin
                if (rx_valid) begin
                    len_hi_d = rx_data;
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    count_d = {len_hi_q, rx_data};
                    word_d  = '0;
                    byte_d  = '0;
                    if (len_bytes > cell_numbers) begin
                        state_d = ERROR;
                    end else if ({len_hi_q, rx_data} == 16'd0) begin
                        state_d = TAIL;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    shift_d = word_in[instr_size-9:0];
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    if (byte_q == BCW'(BPW - 1)) begin
                        // Word complete: register the write; strobe appears next cycle.
                        byte_d  = '0;
                        we_d    = 1'b1;
                        instr_d = word_in;
                        addr_d  = instr_size'(32'(word_q) * BPW);
                        word_d  = word_q + 16'd1;
                        if (({1'b0, word_q} + 17'd1) == {1'b0, count_q}) begin
                            state_d = TAIL;
                        end
                    end else begin
                        byte_d = byte_q + BCW'(1);
                    end
                end
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            CHECK: begin
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? DONE : ERROR;
                end
            end
`endif
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = LEN_HI;
        endcase
    end

    assign we               = we_q;
    assign load_address     = addr_q;
    assign load_instruction = instr_q;
    assign done             = (state_q == DONE);
    assign error            = (state_q == ERROR);
    assign cpu_hold         = (state_q != DONE);

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader: byte streams in, captured memory writes checked.
module tb_instruction_loader;
    localparam int unsigned CELLS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [31:0] load_address;
    logic [31:0] load_instruction;
    logic        we;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  stim[$];

    instruction_loader #(
        .instr_size  (32),
        .cell_numbers(CELLS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .load_address    (load_address),
        .load_instruction(load_instruction),
        .we              (we),
        .cpu_hold        (cpu_hold),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    // Every cycle with we high is logged, so a stretched strobe shows up as an extra write.
    always @(negedge clk) begin
        if (we) begin
            wr_addr.push_back(load_address);
            wr_data.push_back(load_instruction);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the byte's accepting edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_stim(input int maxgap);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < stim.size(); i++) begin
            if (i >= 2) x = x ^ stim[i];
            send_byte(stim[i]);
            if (maxgap > 0) idle($urandom_range(1, maxgap));
        end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic load_two_words(input int maxgap);
        stim = {8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13};
        send_stim(maxgap);
        idle(2);
    endtask

    task automatic check_two_words(input string pfx);
        chk({pfx, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk({pfx, "_a0"}, wr_addr[0], 32'h0000_0000);
            chk({pfx, "_d0"}, wr_data[0], 32'hDEAD_BEEF);
            chk({pfx, "_a1"}, wr_addr[1], 32'h0000_0004);
            chk({pfx, "_d1"}, wr_data[1], 32'h0000_0013);
        end
        chk({pfx, "_done"}, 32'(done), 32'd1);
        chk({pfx, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({pfx, "_err"}, 32'(error), 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_addr", load_address, 32'd0);
        chk("rst_instr", load_instruction, 32'd0);

        // Two words back-to-back, then bytes after DONE are ignored
        load_two_words(0);
        check_two_words("b2b");
        stim = {8'h00, 8'h00, 8'h00, 8'h13};
        for (int i = 0; i < 4; i++) send_byte(stim[i]);
        idle(2);
        chk("after_done_nwr", 32'(wr_addr.size()), 32'd2);
        chk("after_done_done", 32'(done), 32'd1);
        chk("held_addr", load_address, 32'h0000_0004);
        chk("held_instr", load_instruction, 32'h0000_0013);

        // N=0: done on the cycle right after the length
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        chk("n0_done", 32'(done), 32'd1);
        chk("n0_hold", 32'(cpu_hold), 32'd0);
        idle(2);
        chk("n0_nwr", 32'(wr_addr.size()), 32'd0);

        // Oversize: 4*N = CELLS + 4
        do_reset();
        send_byte(8'(((CELLS / 4) + 1) >> 8));
        send_byte(8'((CELLS / 4) + 1));
        chk("big_err", 32'(error), 32'd1);
        chk("big_hold", 32'(cpu_hold), 32'd1);
        chk("big_done", 32'(done), 32'd0);
        stim = {8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send_byte(stim[i]);
        idle(2);
        chk("big_nwr", 32'(wr_addr.size()), 32'd0);
        chk("big_err_sticky", 32'(error), 32'd1);

        // Just-fits boundary: 4*N = CELLS is accepted (no error after length)
        do_reset();
        send_byte(8'((CELLS / 4) >> 8));
        send_byte(8'(CELLS / 4));
        chk("fit_err", 32'(error), 32'd0);
        chk("fit_hold", 32'(cpu_hold), 32'd1);

        // Reset mid-word, with a byte strobed during the reset edge itself
        do_reset();
        stim = {8'h00, 8'h01, 8'h12, 8'h34};
        for (int i = 0; i < 4; i++) send_byte(stim[i]);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        chk("midrst_nwr0", 32'(wr_addr.size()), 32'd0);
        stim = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        send_stim(0);
        idle(2);
        chk("midrst_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("midrst_a0", wr_addr[0], 32'h0000_0000);
            chk("midrst_d0", wr_data[0], 32'h1234_5678);
        end
        chk("midrst_done", 32'(done), 32'd1);

        // Same two-word program with 1-7 idle cycles between strobes
        do_reset();
        load_two_words(7);
        check_two_words("gap");

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        do_reset();
        stim = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 6; i++) send_byte(stim[i]);
        send_byte(8'h04);
        idle(2);
        chk("csum_ok_done", 32'(done), 32'd1);
        chk("csum_ok_nwr", 32'(wr_addr.size()), 32'd1);

        do_reset();
        for (int i = 0; i < 6; i++) send_byte(stim[i]);
        send_byte(8'h05);
        idle(2);
        chk("csum_bad_err", 32'(error), 32'd1);
        chk("csum_bad_done", 32'(done), 32'd0);
        chk("csum_bad_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) chk("csum_bad_d0", wr_data[0], 32'h0102_0304);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
